// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for mem_port_arbiter.
//   arb_state_t : arbiter FSM states (IDLE, SERVE, ACK)
//   owner_t     : which port owns the in-flight transaction
//   ADDR_W_DEF / DATA_W_DEF / PROT_LIMIT_DEF : parameter defaults
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF     = 8;
  localparam int unsigned DATA_W_DEF     = 16;
  localparam logic [7:0]  PROT_LIMIT_DEF = 8'h10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    ACK   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-ported 256x16 memory between the
// instruction-fetch port (read only) and the load/store data port.
// One transaction at a time: grant -> SERVE (memory driven) -> ACK pulse.
// Fixed priority D over IF; the port being acked is masked during ACK so
// back-to-back requests alternate.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   if_req/if_addr -> if_ack/if_rdata          fetch port
//   d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata/d_err   data port
//   Mem_Addr, MemW_Data_f, MemW_Data_b, MemW_en -> memory
//   MemR_Data <- memory (combinational read)
//
// Build option: define MEM_ARB_WPROT_EN to block D writes below PROT_LIMIT
// (write suppressed, d_err raised with d_ack).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W     = ADDR_W_DEF,
  parameter int unsigned       DATA_W     = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] PROT_LIMIT = ADDR_W'(PROT_LIMIT_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [15:0]       Mem_Addr,
  output logic [7:0]        MemW_Data_f,
  output logic [7:0]        MemW_Data_b,
  output logic              MemW_en,
  input  logic [15:0]       MemR_Data
);

`ifdef MEM_ARB_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              blocked_q, blocked_d;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              d_grant, if_grant;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Grant and next-state logic; grants only happen outside SERVE, and in
  // ACK the port being acked is masked since its req may still be high.
  always_comb begin
    d_grant   = 1'b0;
    if_grant  = 1'b0;
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    blocked_d = blocked_q;
    if (state_q == SERVE) begin
      state_d = ACK;
    end else begin
      d_grant  = d_req && !(state_q == ACK && owner_q == OWN_D);
      if_grant = if_req && !(state_q == ACK && owner_q == OWN_IF) && !d_grant;
      state_d  = (d_grant || if_grant) ? SERVE : IDLE;
      if (d_grant) begin
        owner_d   = OWN_D;
        addr_d    = d_addr;
        wdata_d   = d_we ? d_wdata : '0;
        we_d      = d_we;
        blocked_d = WPROT && d_we && (d_addr < PROT_LIMIT);
      end else if (if_grant) begin
        owner_d   = OWN_IF;
        addr_d    = if_addr;
        wdata_d   = '0;
        we_d      = 1'b0;
        blocked_d = 1'b0;
      end
    end
  end

  // Latched transaction and per-port read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      blocked_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      blocked_q <= blocked_d;
      if (state_q == SERVE) begin
        if (owner_q == OWN_IF) if_rdata_q <= MemR_Data;
        else if (!we_q)        d_rdata_q  <= MemR_Data;
      end
    end
  end

  // Outputs decoded from state so they drop asynchronously with reset
  always_comb begin
    if_ack      = (state_q == ACK) && (owner_q == OWN_IF);
    d_ack       = (state_q == ACK) && (owner_q == OWN_D);
    d_err       = d_ack && blocked_q;
    MemW_en     = (state_q == SERVE) && (owner_q == OWN_D) && we_q && !blocked_q;
    MemW_Data_f = MemW_en ? wdata_q[DATA_W-1 -: 8] : '0;
    MemW_Data_b = MemW_en ? wdata_q[7:0] : '0;
    Mem_Addr    = {{(16-ADDR_W){1'b0}}, addr_q};
    if_rdata    = if_rdata_q;
    d_rdata     = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed plus randomized checks of mem_port_arbiter
// against a word-level model of the memory and the per-port read results.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [7:0]  if_addr = '0, d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        if_ack, d_ack, d_err, MemW_en;
  logic [15:0] if_rdata, d_rdata, Mem_Addr, MemR_Data;
  logic [7:0]  MemW_Data_f, MemW_Data_b;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .PROT_LIMIT(8'h10)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .Mem_Addr(Mem_Addr), .MemW_Data_f(MemW_Data_f), .MemW_Data_b(MemW_Data_b),
    .MemW_en(MemW_en), .MemR_Data(MemR_Data)
  );

  // Environment memory (Mem_256x16): combinational read, clocked write
  logic [15:0] mem [256];
  logic        init_pulse = 1'b1;

  function automatic logic [15:0] pattern(int unsigned i);
    return 16'(i * 32'h0101) ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    if (init_pulse) begin
      for (int i = 0; i < 256; i++) mem[i] <= pattern(i);
    end else if (MemW_en) begin
      mem[Mem_Addr[7:0]] <= {MemW_Data_f, MemW_Data_b};
    end
  end
  assign MemR_Data = mem[Mem_Addr[7:0]];

  // Reference model state
  logic [15:0] ref_mem [256];
  logic [15:0] exp_if_rdata = '0, exp_d_rdata = '0;
  int unsigned n_chk = 0, n_fail = 0;

  function automatic bit prot(logic [7:0] a, logic we);
`ifdef MEM_ARB_WPROT_EN
    return we && (a < 8'h10);
`else
    return 1'b0 && we && (a < 8'h10);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One isolated transaction: checks SERVE drive, 2-cycle latency, ack, data
  task automatic run_txn(input bit is_d, input bit we, input logic [7:0] addr,
                         input logic [15:0] wdata, input string tag);
    int  lat;
    bit  seen;
    bit  blk;
    bit  wr;
    blk = is_d && prot(addr, we);
    wr  = is_d && we && !blk;
    @(negedge clk);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk({tag, ".addr"}, 32'(Mem_Addr), 32'({8'h00, addr}));
        chk({tag, ".wen"},  32'(MemW_en), 32'(wr));
        chk({tag, ".wdat"}, 32'({MemW_Data_f, MemW_Data_b}), 32'(wr ? wdata : 16'h0000));
      end
      if (d_ack || if_ack) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    chk({tag, ".lat"}, 32'(lat), 32'd2);
    if (seen) begin
      if (is_d && we) begin
        if (!blk) ref_mem[addr] = wdata;
      end else if (is_d) begin
        exp_d_rdata = ref_mem[addr];
      end else begin
        exp_if_rdata = ref_mem[addr];
      end
      chk({tag, ".ack"},  32'({if_ack, d_ack}), 32'(is_d ? 2'b01 : 2'b10));
      chk({tag, ".drd"},  32'(d_rdata), 32'(exp_d_rdata));
      chk({tag, ".ifrd"}, 32'(if_rdata), 32'(exp_if_rdata));
      chk({tag, ".err"},  32'(d_err), 32'(blk));
    end
    d_req = 1'b0; if_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".acks"}, 32'({if_ack, d_ack, d_err, MemW_en}), 32'd0);
    chk({tag, ".ifrd"}, 32'(if_rdata), 32'd0);
    chk({tag, ".drd"},  32'(d_rdata), 32'd0);
    chk({tag, ".mem"},  32'({Mem_Addr, MemW_Data_f, MemW_Data_b}), 32'd0);
  endtask

  initial begin
    int dk, ik;
    bit both;
    for (int i = 0; i < 256; i++) ref_mem[i] = pattern(i);
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    init_pulse = 1'b0;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Directed: write then read back through both ports
    run_txn(1'b1, 1'b1, 8'h20, 16'hA50F, "dwr20");
    run_txn(1'b1, 1'b0, 8'h20, 16'h0000, "drd20");
    run_txn(1'b0, 1'b0, 8'h20, 16'h0000, "ifrd20");
    run_txn(1'b0, 1'b0, 8'h07, 16'h0000, "ifrd07");

    // Simultaneous requests: D first, IF two cycles later, never both
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
    if_req = 1'b1; if_addr = 8'h21;
    dk = 0; ik = 0; both = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (d_ack && if_ack) both = 1'b1;
      if (d_ack && dk == 0) begin
        dk = k;
        exp_d_rdata = ref_mem[8'h20];
        chk("simul.drd", 32'(d_rdata), 32'(exp_d_rdata));
        d_req = 1'b0;
      end
      if (if_ack && ik == 0) begin
        ik = k;
        exp_if_rdata = ref_mem[8'h21];
        chk("simul.ifrd", 32'(if_rdata), 32'(exp_if_rdata));
        if_req = 1'b0;
      end
    end
    d_req = 1'b0; if_req = 1'b0;
    chk("simul.dlat", 32'(dk), 32'd2);
    chk("simul.iflat", 32'(ik), 32'd4);
    chk("simul.both", 32'(both), 32'd0);

    // Continuous requests: 8 transactions alternating D, IF
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h40;
    if_req = 1'b1; if_addr = 8'h41;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("alt.dack",  32'(d_ack),  32'((k % 4) == 2));
      chk("alt.ifack", 32'(if_ack), 32'((k % 4) == 0));
      if ((k % 4) == 2) begin
        exp_d_rdata = ref_mem[8'h40];
        chk("alt.drd", 32'(d_rdata), 32'(exp_d_rdata));
      end
      if ((k % 4) == 0) begin
        exp_if_rdata = ref_mem[8'h41];
        chk("alt.ifrd", 32'(if_rdata), 32'(exp_if_rdata));
      end
    end
    d_req = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("alt.idle", 32'({if_ack, d_ack}), 32'd0);

    // Protected-region write and read-back of the same word
    run_txn(1'b1, 1'b1, 8'h05, 16'hFFFF, "prot_wr");
    run_txn(1'b1, 1'b0, 8'h05, 16'h0000, "prot_rd");

    // Randomized single transactions
    for (int n = 0; n < 24; n++) begin
      bit          rd_is_d, rw;
      logic [7:0]  ra;
      logic [15:0] rdat;
      rd_is_d = 1'($urandom_range(0, 1));
      rw      = rd_is_d && 1'($urandom_range(0, 1));
      ra      = 8'($urandom_range(0, 255));
      rdat    = 16'($urandom);
      run_txn(rd_is_d, rw, ra, rdat, "rand");
    end

    // Reset asserted mid-SERVE of a write
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h30; d_wdata = 16'h1234;
    @(negedge clk);
    chk("rst.wen_before", 32'(MemW_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    d_req = 1'b0; d_we = 1'b0;
    exp_d_rdata  = '0;
    exp_if_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    ref_mem[8'h30] = mem[8'h30];
    rst_n = 1'b1;
    run_txn(1'b0, 1'b0, 8'h20, 16'h0000, "post_rst_if");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter that shares the single-ported `Mem_256x16` between the instruction-fetch path and the load/store data path of the multi-cycle 16-bit RISC. It latches one request per transaction, drives the memory's address, split write-data and write-enable lines, and captures read data into per-port registers. A one-cycle ack handshake returns results to the requester.

## Interface
- `ADDR_W`, 8: memory word address width; the upper 8 bits of `Mem_Addr` are tied to 0.
- `DATA_W`, 16: memory word width.
- `PROT_LIMIT`, 8'h10: first writable address when write protection is compiled in.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch read request; held until `if_ack`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_ack`  out  1  one-cycle pulse; `if_rdata` is valid.
- `if_rdata`  out  DATA_W  registered fetch data, held until the next `if_ack`.
- `d_req`  in  1  data request; held until `d_ack`.
- `d_we`  in  1  1 = write, 0 = read; sampled with `d_req`.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  write data.
- `d_ack`  out  1  one-cycle completion pulse.
- `d_rdata`  out  DATA_W  registered read data, held until the next read `d_ack`.
- `d_err`  out  1  valid with `d_ack`; protected-write violation.
- `Mem_Addr`  out  16  `{8'h00, addr_q}`.
- `MemW_Data_f`  out  8  `wdata_q[15:8]`; 0 unless writing.
- `MemW_Data_b`  out  8  `wdata_q[7:0]`; 0 unless writing.
- `MemW_en`  out  1  memory write enable.
- `MemR_Data`  in  16  memory read data, combinational from `Mem_Addr`.

## Operation
**States**
- IDLE: no transaction in progress.
- SERVE: the memory is driven from the latched `addr_q`, `wdata_q` and `we_q`, and the latched `owner` (IF or D) records which port is being served.
- ACK: the owner's ack is high.

**Grant**
- Grants are evaluated in IDLE and ACK.
- Priority is fixed: D beats IF.
- In ACK, the port currently being acked is masked, because its `req` may still be high this cycle.
- Granting latches the winning port's address, data and `we`; IF always latches `we = 0`.
- The next state is SERVE if a grant is made, otherwise IDLE.

**SERVE**
- `MemW_en = (owner == D) & we_q & ~blocked`.
- At the end of SERVE the memory commits the write, and read data from `MemR_Data` is captured into the owner's `rdata` register.
- Writes leave `d_rdata` unchanged.

**ACK and the requester handshake**
- The requester must drop `req` in the cycle after it sees ack.
- Keeping `req` high in that cycle counts as a new request.

**Reset and unused lines**
- Reset can be asserted at any time, including mid-SERVE. It immediately forces IDLE, and all outputs go to 0.
- The interrupted write is not guaranteed; `MemW_en` is decoded from state, so it drops asynchronously.
- When `d_we = 0`, `d_wdata` is ignored.
- `if_addr`/`d_addr` values above 8 bits are not representable; `ADDR_W` bounds them.

## Timing
- Reset values of every output: `if_ack`, `d_ack`, `d_err`, `MemW_en` = 0; `if_rdata`, `d_rdata` = 16'h0000; `Mem_Addr`, `MemW_Data_f`, `MemW_Data_b` = 0.
- Request sampled in IDLE at edge E → SERVE in cycle E+1 → ack high in cycle E+2. Latency is 2 cycles and `rdata` is valid in the ack cycle.
- Back-to-back transactions overlap ACK and grant: with both ports requesting continuously, service alternates D, IF, D, … at one transaction per 2 cycles.
- Only one ack is high in any cycle.
- `Mem_Addr` changes only on entry to SERVE and holds for the full SERVE cycle.

## Configuration
- `MEM_ARB_WPROT_EN` defined:
  - a D write with `addr < PROT_LIMIT` sets `blocked`, which keeps `MemW_en = 0`;
  - the memory is unchanged;
  - `d_ack` still pulses with `d_err = 1`.
- Undefined: `blocked` and `d_err` are constant 0 and every write commits.

## Structure
- `mem_arb_pkg` holds:
  - the `arb_state_t` enum (IDLE, SERVE, ACK);
  - the `owner_t` enum (OWN_IF, OWN_D);
  - `ADDR_W`/`DATA_W` defaults;
  - the `PROT_LIMIT` default.
- Single module, no sub-module; the grant logic is a few lines and stays inline.

## Test plan
- Reset, then D write 16'hA50F to addr 8'h20 → in SERVE, `MemW_en=1`, `Mem_Addr=16'h0020`, `MemW_Data_f=8'hA5`, `MemW_Data_b=8'h0F`; `d_ack` in cycle E+2.
- D read of 8'h20 → `d_ack` with `d_rdata=16'hA50F`; IF read of 8'h20 → `if_rdata=16'hA50F` and `d_rdata` unchanged.
- `if_req` and `d_req` rise on the same edge → D is served first; `if_ack` comes exactly 2 cycles after `d_ack`, with no cycle where both acks are high.
- Both requests held high for 8 transactions → acks alternate D, IF, D, … at one per 2 cycles.
- With `MEM_ARB_WPROT_EN`, D write 16'hFFFF to 8'h05 → `MemW_en` stays 0, `d_err=1` with `d_ack`, and a later read of 8'h05 returns the old value. Without the macro the write commits and `d_err=0`.
- Assert `rst_n=0` mid-SERVE of a write → `MemW_en` drops immediately and all outputs are 0; after release, a new IF request completes normally.
